chebyshev_series_eval: RTL and testbench

//  Parametrised Chebyshev-series evaluator: y = sum_{k=0..ORDER} c_k*T_k(x), via the Clenshaw recurrence.

---
 rtl/chebyshev_series_eval_if.sv | 30 +++
 rtl/chebyshev_series_eval.sv | 130 +++++++++++++
 tb/tb_chebyshev_series_eval.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chebyshev_series_eval_if.sv
// Coefficient-write, sample-in and result-out signals of chebyshev_series_eval.
// The design takes the slave modport; the upstream/downstream side takes master.
interface chebyshev_series_eval_if #(
    parameter int unsigned WL    = 8,
    parameter int unsigned CL    = 8,
    parameter int unsigned ORDER = 4
);
    localparam int unsigned AAW = $clog2(ORDER + 1);

    logic           coeff_we;
    logic [AAW-1:0] coeff_addr;
    logic [CL-1:0]  coeff_in;
    logic           in_valid;
    logic           in_ready;
    logic [WL-1:0]  data_in;
    logic           out_valid;
    logic           out_ready;
    logic [CL-1:0]  data_out;
    logic           ovf;

    modport master (
        output coeff_we, coeff_addr, coeff_in, in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, ovf
    );

    modport slave (
        input  coeff_we, coeff_addr, coeff_in, in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, ovf
    );
endinterface

// File: rtl/chebyshev_series_eval.sv
// Chebyshev series y = sum c_k*T_k(x) evaluated with the Clenshaw recurrence, one k per cycle.
// Define CHEB_SAT_EN to saturate the result to CL bits and flag clipping on ovf; otherwise it wraps.
module chebyshev_series_eval #(
    parameter int unsigned WL    = 8,
    parameter int unsigned CL    = 8,
    parameter int unsigned CFRAC = 4,
    parameter int unsigned ORDER = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    chebyshev_series_eval_if.slave bus
);
    localparam int unsigned AW  = CL + 2 * $clog2(ORDER + 2);
    localparam int unsigned AAW = $clog2(ORDER + 1);
    localparam int unsigned PW  = WL + AW;

    // Coefficients, accumulator and output all share CFRAC fractional bits.
    if (CFRAC >= CL) begin : g_cfrac_chk
        $error("CFRAC must be smaller than CL");
    end

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FINAL, S_DONE} state_t;

    state_t               r_state, w_next;
    logic signed [CL-1:0] r_coef [ORDER+1];
    logic signed [WL-1:0] r_x;
    logic signed [AW-1:0] r_b1, r_b2;
    logic [AAW-1:0]       r_k;
    logic                 r_in_ready, r_out_valid, r_ovf;
    logic [CL-1:0]        r_data_out;

    logic signed [AW-1:0] w_xb1, w_ck, w_c0, w_b_new;
    logic                 w_accept, w_coef_wr, w_ovf;
    logic [CL-1:0]        w_y_out;

    assign w_accept  = bus.in_valid && r_in_ready;
    assign w_coef_wr = bus.coeff_we && (r_state == S_IDLE) && (32'(bus.coeff_addr) <= ORDER);

    // x*b1 at full width, floor-shifted back to the accumulator's fractional scale.
    assign w_xb1   = AW'((PW'(r_x) * PW'(r_b1)) >>> (WL - 1));
    assign w_ck    = AW'(r_coef[r_k]);
    assign w_c0    = AW'(r_coef[0]);
    assign w_b_new = w_ck + (w_xb1 << 1) - r_b2;

`ifdef CHEB_SAT_EN
    localparam logic signed [AW-1:0] Y_MAX = AW'((1 << (CL - 1)) - 1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;
    logic signed [AW-1:0] w_y;
    assign w_y = w_c0 + w_xb1 - r_b2;

    always_comb begin
        w_y_out = w_y[CL-1:0];
        w_ovf   = 1'b0;
        if (w_y > Y_MAX) begin
            w_y_out = Y_MAX[CL-1:0];
            w_ovf   = 1'b1;
        end else if (w_y < Y_MIN) begin
            w_y_out = Y_MIN[CL-1:0];
            w_ovf   = 1'b1;
        end
    end
`else
    assign w_y_out = CL'(w_c0 + w_xb1 - r_b2);
    assign w_ovf   = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ITER;
            S_ITER:  if (r_k == AAW'(1)) w_next = S_FINAL;
            S_FINAL: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake flags follow the state being entered, so both are low during reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i <= ORDER; i++) r_coef[i] <= '0;
            r_x        <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_k        <= '0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_coef_wr) r_coef[bus.coeff_addr] <= bus.coeff_in;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_x  <= bus.data_in;
                    r_k  <= AAW'(ORDER);
                    r_b1 <= '0;
                    r_b2 <= '0;
                end
                S_ITER: begin
                    r_b1 <= w_b_new;
                    r_b2 <= r_b1;
                    r_k  <= r_k - AAW'(1);
                end
                S_FINAL: begin
                    r_data_out <= w_y_out;
                    r_ovf      <= w_ovf;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_data_out;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_chebyshev_series_eval.sv
// Randomised bench for chebyshev_series_eval against an arithmetic Clenshaw model and a result queue.
module tb_chebyshev_series_eval;
    localparam int WL    = 8;
    localparam int CL    = 8;
    localparam int CFRAC = 4;
    localparam int ORDER = 4;
    localparam int AW    = CL + 2 * $clog2(ORDER + 2);
    localparam int AAW   = $clog2(ORDER + 1);

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    chebyshev_series_eval_if #(.WL(WL), .CL(CL), .ORDER(ORDER)) bus ();

    chebyshev_series_eval #(.WL(WL), .CL(CL), .CFRAC(CFRAC), .ORDER(ORDER)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [CL-1:0] d;
        logic          ov;
    } exp_t;

    logic [CL-1:0] m_coef [ORDER+1];
    exp_t          exp_q [$];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap_aw(input longint v);
        longint m;
        longint r;
        m = 64'sd1 <<< AW;
        r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint sext(input logic [CL-1:0] c);
        return longint'($signed(c));
    endfunction

    // Clenshaw in plain integers: b_k = c_k + 2*x*b_{k+1} - b_{k+2}; y = c_0 + x*b_1 - b_2.
    function automatic exp_t model(input logic [WL-1:0] x);
        longint xv, b1, b2, bn, p, y, ymax;
        exp_t   r;
        xv = longint'($signed(x));
        b1 = 0;
        b2 = 0;
        for (int k = ORDER; k >= 1; k--) begin
            p  = wrap_aw((xv * b1) >>> (WL - 1));
            bn = wrap_aw(sext(m_coef[k]) + wrap_aw(2 * p) - b2);
            b2 = b1;
            b1 = bn;
        end
        p    = wrap_aw((xv * b1) >>> (WL - 1));
        y    = wrap_aw(sext(m_coef[0]) + p - b2);
        ymax = (64'sd1 <<< (CL - 1)) - 1;
`ifdef CHEB_SAT_EN
        if (y > ymax) begin
            y = ymax;
            r.ov = 1'b1;
        end else if (y < -ymax - 1) begin
            y = -ymax - 1;
            r.ov = 1'b1;
        end else begin
            r.ov = 1'b0;
        end
`else
        r.ov = 1'b0;
`endif
        r.d = y[CL-1:0];
        return r;
    endfunction

    // Every valid cycle must show the oldest outstanding result.
    always @(negedge clock) begin
        if (resetn && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("data_out", bus.data_out, exp_q[0].d);
                check("ovf", bus.ovf, exp_q[0].ov);
            end
        end
    end

    always @(posedge clock) begin
        if (resetn && bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic wr(input int a, input logic [CL-1:0] v);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = AAW'(a);
        bus.coeff_in   = v;
        @(posedge clock);
        #1;
        bus.coeff_we = 1'b0;
        if (a <= ORDER) m_coef[a] = v;
    endtask

    task automatic wait_in_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    task automatic run(input logic [WL-1:0] x, input int hold, input bit inject,
                       input bit chk_lit, input logic [CL-1:0] lit, input bit lit_ov,
                       input bit same_wr, input int wa, input logic [CL-1:0] wv);
        bit            ok, got;
        logic [CL-1:0] d0;
        wait_in_ready(ok);
        if (!ok) return;
        bus.data_in  = x;
        bus.in_valid = 1'b1;
        if (same_wr) begin
            bus.coeff_we   = 1'b1;
            bus.coeff_addr = AAW'(wa);
            bus.coeff_in   = wv;
            if (wa <= ORDER) m_coef[wa] = wv;
        end
        exp_q.push_back(model(x));
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.coeff_we = 1'b0;
        got = 1'b0;
        for (int l = 1; l <= 40; l++) begin
            @(negedge clock);
            if (inject && l == 2) begin
                bus.in_valid   = 1'b1;
                bus.data_in    = ~x;
                bus.coeff_we   = 1'b1;
                bus.coeff_addr = '0;
                bus.coeff_in   = 8'h55;
            end else if (inject && l == 3) begin
                bus.in_valid = 1'b0;
                bus.coeff_we = 1'b0;
                check("busy_in_ready", bus.in_ready, 0);
            end
            if (bus.out_valid) begin
                got = 1'b1;
                check("latency", l, ORDER + 2);
                break;
            end
        end
        if (!got) begin
            check("out_valid_timeout", 0, 1);
            exp_q.delete();
            return;
        end
        if (chk_lit) begin
            check("lit_data", bus.data_out, lit);
            check("lit_ovf", bus.ovf, lit_ov);
        end
        d0 = bus.data_out;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.data_out, d0);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        check("post_in_ready", bus.in_ready, 1);
        check("post_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.coeff_we = 0; bus.coeff_addr = '0; bus.coeff_in = '0;
        bus.in_valid = 0; bus.data_in = '0; bus.out_ready = 0;
        for (int i = 0; i <= ORDER; i++) m_coef[i] = '0;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_ovf", bus.ovf, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // Model anchored to hand values: 1.0*T0, 1.0*T1(0.5)=0.5, 1.0*T2(0.5)=-0.5.
        wr(0, 8'h10);
        run(8'h40, 0, 0, 1, 8'h10, 0, 0, 0, 0);
        wr(0, 8'h00); wr(1, 8'h10);
        run(8'h40, 0, 0, 1, 8'h08, 0, 0, 0, 0);
        wr(1, 8'h00); wr(2, 8'h10);
        run(8'h40, 0, 0, 1, 8'hF8, 0, 0, 0, 0);

        // Stall with dropped write and extra sample mid-ITER; the next result still uses c2 only.
        run(8'h40, 3, 1, 1, 8'hF8, 0, 0, 0, 0);
        run(8'h40, 0, 0, 1, 8'hF8, 0, 0, 0, 0);

        for (int k = 0; k <= ORDER; k++) wr(k, 8'h7F);
`ifdef CHEB_SAT_EN
        run(8'h7F, 0, 0, 1, 8'h7F, 1, 0, 0, 0);
`else
        run(8'h7F, 0, 0, 0, 8'h00, 0, 0, 0, 0);
`endif

        wr(5, 8'h33);
        run(8'hC0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        run(8'h40, 0, 0, 0, 8'h00, 0, 1, 3, 8'h08);

        // Abort mid-ITER: everything clears asynchronously, bank included.
        wait_in_ready(ok);
        bus.data_in  = 8'h40;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_data_out", bus.data_out, 0);
        check("abort_ovf", bus.ovf, 0);
        exp_q.delete();
        for (int i = 0; i <= ORDER; i++) m_coef[i] = '0;
        @(negedge clock);
        resetn = 1'b1;
        run(8'h40, 0, 0, 1, 8'h00, 0, 0, 0, 0);

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) wr($urandom_range(0, 7), CL'($urandom));
            run(WL'($urandom), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), 0, 8'h00, 0,
                ($urandom_range(0, 2) == 0), $urandom_range(0, ORDER), CL'($urandom));
        end

        repeat (3) @(negedge clock);
        check("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
